// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life generation scheduler: state encodings
// and default board geometry.
package gol_pkg;

  localparam int GOL_ROWS  = 16;
  localparam int GOL_GEN_W = 16;

  typedef enum logic [2:0] {
    ST_SETUP   = 3'd0,
    ST_PAUSED  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_COMMIT  = 3'd4
  } gol_state_e;

endpackage

// File: rtl/gol_tick_divider.sv
// Generation pacing counter: restarts on start, counts while run is high and
// flags done on the TICK_DIV-th counted cycle.
module gol_tick_divider #(
  parameter int TICK_DIV = 8192
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (run && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = run && (cnt == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/gol_generation_scheduler.sv
// Run/pause/step control for a row-serial Game-of-Life datapath.
// Optional fixed-point detection is enabled by defining GOL_STABLE_DETECT_EN.
module gol_generation_scheduler
  import gol_pkg::*;
#(
  parameter  int ROWS     = GOL_ROWS,
  parameter  int TICK_DIV = 8192,
  parameter  int GEN_W    = GOL_GEN_W,
  localparam int IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_run_i,
  input  logic             btn_step_i,
  input  logic             btn_clear_i,
  output logic             row_req_o,
  output logic [IDX_W-1:0] row_idx_o,
  input  logic             row_ack_i,
  input  logic             row_changed_i,
  output logic             commit_o,
  output logic             edit_en_o,
  output logic [GEN_W-1:0] gen_cnt_o,
  output logic [2:0]       state_o,
  output logic             stable_o
);

  gol_state_e       state, state_nxt;
  logic             run_mode, run_mode_nxt;
  logic [IDX_W-1:0] row_idx;
  logic [GEN_W-1:0] gen_cnt;
  logic             tick_start, tick_done;
  logic             last_ack;
  logic             gen_stable;

  assign last_ack = (state == ST_COMPUTE) && row_ack_i &&
                    (row_idx == IDX_W'(ROWS - 1));

  // Clear outranks run, run outranks step; the losing pulse is simply dropped.
  always_comb begin
    state_nxt    = state;
    run_mode_nxt = run_mode;
    if (btn_clear_i) begin
      state_nxt    = ST_SETUP;
      run_mode_nxt = 1'b0;
    end else begin
      case (state)
        ST_SETUP, ST_PAUSED: begin
          if (btn_run_i) begin
            state_nxt    = ST_WAIT;
            run_mode_nxt = 1'b1;
          end else if (btn_step_i) begin
            state_nxt    = ST_COMPUTE;
            run_mode_nxt = 1'b0;
          end
        end
        ST_WAIT: begin
          if (btn_run_i) begin
            state_nxt    = ST_PAUSED;
            run_mode_nxt = 1'b0;
          end else if (tick_done) begin
            state_nxt = ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (btn_run_i) run_mode_nxt = 1'b0;
          if (last_ack) state_nxt = ST_COMMIT;
        end
        ST_COMMIT: begin
          if (btn_run_i) run_mode_nxt = 1'b0;
          if (gen_stable) begin
            run_mode_nxt = 1'b0;
            state_nxt    = ST_PAUSED;
          end else if (run_mode_nxt) begin
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = ST_PAUSED;
          end
        end
        default: begin
          state_nxt    = ST_SETUP;
          run_mode_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_SETUP;
      run_mode <= 1'b0;
      row_idx  <= '0;
      gen_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      run_mode <= run_mode_nxt;
      // Index parks at 0 outside COMPUTE so every sweep starts from row 0.
      if (state_nxt != ST_COMPUTE) begin
        row_idx <= '0;
      end else if ((state == ST_COMPUTE) && row_ack_i) begin
        row_idx <= row_idx + 1'b1;
      end
      if (btn_clear_i) begin
        gen_cnt <= '0;
      end else if ((state == ST_COMMIT) && !gen_stable) begin
        gen_cnt <= gen_cnt + 1'b1;
      end
    end
  end

  assign tick_start = (state_nxt == ST_WAIT) && (state != ST_WAIT);

  gol_tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .start (tick_start),
    .run   (state == ST_WAIT),
    .done  (tick_done)
  );

`ifdef GOL_STABLE_DETECT_EN
  logic changed_acc;
  logic stable_q;
  logic compute_entry;

  assign compute_entry = (state_nxt == ST_COMPUTE) && (state != ST_COMPUTE);
  assign gen_stable    = !changed_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      changed_acc <= 1'b0;
      stable_q    <= 1'b0;
    end else begin
      if (compute_entry) begin
        changed_acc <= 1'b0;
      end else if ((state == ST_COMPUTE) && row_ack_i && row_changed_i) begin
        changed_acc <= 1'b1;
      end
      if (btn_clear_i || compute_entry) begin
        stable_q <= 1'b0;
      end else if ((state == ST_COMMIT) && gen_stable) begin
        stable_q <= 1'b1;
      end
    end
  end

  assign stable_o = stable_q;
`else
  logic unused_row_changed;

  assign unused_row_changed = row_changed_i;
  assign gen_stable         = 1'b0;
  assign stable_o           = 1'b0;
`endif

  assign row_req_o = (state == ST_COMPUTE);
  assign row_idx_o = row_idx;
  assign commit_o  = (state == ST_COMMIT);
  assign edit_en_o = (state == ST_SETUP);
  assign gen_cnt_o = gen_cnt;
  assign state_o   = state;

endmodule

// File: tb/tb_gol_generation_scheduler.sv
// Directed bench for gol_generation_scheduler with ROWS=16, TICK_DIV=4, GEN_W=4.
module tb_gol_generation_scheduler;

  localparam int ROWS     = 16;
  localparam int TICK_DIV = 4;
  localparam int GEN_W    = 4;

  localparam logic [2:0] S_SETUP   = 3'd0;
  localparam logic [2:0] S_PAUSED  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_COMMIT  = 3'd4;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_run_i, btn_step_i, btn_clear_i;
  logic             row_req_o;
  logic [3:0]       row_idx_o;
  logic             row_ack_i, row_changed_i;
  logic             commit_o, edit_en_o, stable_o;
  logic [GEN_W-1:0] gen_cnt_o;
  logic [2:0]       state_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gol_generation_scheduler #(
    .ROWS     (ROWS),
    .TICK_DIV (TICK_DIV),
    .GEN_W    (GEN_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_run_i     (btn_run_i),
    .btn_step_i    (btn_step_i),
    .btn_clear_i   (btn_clear_i),
    .row_req_o     (row_req_o),
    .row_idx_o     (row_idx_o),
    .row_ack_i     (row_ack_i),
    .row_changed_i (row_changed_i),
    .commit_o      (commit_o),
    .edit_en_o     (edit_en_o),
    .gen_cnt_o     (gen_cnt_o),
    .state_o       (state_o),
    .stable_o      (stable_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic r, input logic s, input logic c);
    btn_run_i   = r;
    btn_step_i  = s;
    btn_clear_i = c;
    tick();
    btn_run_i   = 1'b0;
    btn_step_i  = 1'b0;
    btn_clear_i = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (state_o === s) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    if (state_o === s) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_run_i = 0; btn_step_i = 0; btn_clear_i = 0;
    row_ack_i = 0; row_changed_i = 0;
    #3;
    n_checks++;
    if (state_o !== S_SETUP) $display("FAIL reset_state: got %0d want %0d", state_o, S_SETUP);
    else n_pass++;
    n_checks++;
    if ({edit_en_o, row_req_o, commit_o, stable_o} !== 4'b1000)
      $display("FAIL reset_flags: got edit/req/commit/stable=%b want 1000",
               {edit_en_o, row_req_o, commit_o, stable_o});
    else n_pass++;
    n_checks++;
    if ({row_idx_o, gen_cnt_o} !== 8'h00)
      $display("FAIL reset_counts: got idx=%0d gen=%0d want 0 0", row_idx_o, gen_cnt_o);
    else n_pass++;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (state_o !== S_SETUP) $display("FAIL reset_release: got %0d want %0d", state_o, S_SETUP);
    else n_pass++;
  endtask

  task automatic test_step();
    bit seq_ok = 1'b1;
    int req_cycles = 0;
    row_ack_i = 1'b1;
    pulse(0, 1, 0);
    for (int i = 0; i < ROWS; i++) begin
      if (!(state_o === S_COMPUTE && row_req_o === 1'b1 && row_idx_o === 4'(i) &&
            commit_o === 1'b0 && edit_en_o === 1'b0))
        seq_ok = 1'b0;
      if (row_req_o === 1'b1) req_cycles++;
      tick();
    end
    n_checks++;
    if (seq_ok !== 1'b1) $display("FAIL step_row_sequence: got bad req/idx sequence want idx 0..15 with req high");
    else n_pass++;
    n_checks++;
    if ({state_o, commit_o, row_req_o} !== {S_COMMIT, 2'b10})
      $display("FAIL step_commit: got state=%0d commit=%b req=%b want 4 1 0", state_o, commit_o, row_req_o);
    else n_pass++;
    tick();
    if (row_req_o === 1'b1) req_cycles++;
    n_checks++;
    if (req_cycles !== ROWS) $display("FAIL step_req_cycles: got %0d want %0d", req_cycles, ROWS);
    else n_pass++;
    n_checks++;
    if ({state_o, gen_cnt_o, commit_o} !== {S_PAUSED, 4'd1, 1'b0})
      $display("FAIL step_after: got state=%0d gen=%0d commit=%b want 1 1 0", state_o, gen_cnt_o, commit_o);
    else n_pass++;
  endtask

  task automatic test_ack_delay();
    int hold5 = 0;
    bit req_ok = 1'b1;
    bit ok = 1'b0;
    row_ack_i = 1'b0;
    pulse(0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      if (state_o === S_COMMIT) begin
        ok = 1'b1;
        break;
      end
      if (row_idx_o === 4'd5) begin
        hold5++;
        if (row_req_o !== 1'b1) req_ok = 1'b0;
      end
      row_ack_i = (row_idx_o !== 4'd5) || (hold5 >= 4);
      tick();
    end
    row_ack_i = 1'b1;
    n_checks++;
    if (ok !== 1'b1) $display("FAIL ack_delay_timeout: got state=%0d want %0d", state_o, S_COMMIT);
    else n_pass++;
    n_checks++;
    if (hold5 !== 4) $display("FAIL ack_delay_hold: got row5 cycles=%0d want 4", hold5);
    else n_pass++;
    n_checks++;
    if (req_ok !== 1'b1) $display("FAIL ack_delay_req: got req dropped on row 5 want held high");
    else n_pass++;
    tick();
    n_checks++;
    if ({state_o, gen_cnt_o} !== {S_PAUSED, 4'd2})
      $display("FAIL ack_delay_after: got state=%0d gen=%0d want 1 2", state_o, gen_cnt_o);
    else n_pass++;
  endtask

  task automatic test_clear();
    bit saw_commit = 1'b0;
    bit ok = 1'b0;
    row_ack_i = 1'b1;
    pulse(0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      if (commit_o === 1'b1) saw_commit = 1'b1;
      if (row_idx_o === 4'd9) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL clear_reach_row9: got idx=%0d want 9", row_idx_o);
    else n_pass++;
    pulse(0, 0, 1);
    n_checks++;
    if ({state_o, row_req_o, edit_en_o} !== {S_SETUP, 2'b01})
      $display("FAIL clear_state: got state=%0d req=%b edit=%b want 0 0 1", state_o, row_req_o, edit_en_o);
    else n_pass++;
    n_checks++;
    if ({row_idx_o, gen_cnt_o} !== 8'h00)
      $display("FAIL clear_counts: got idx=%0d gen=%0d want 0 0", row_idx_o, gen_cnt_o);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (commit_o === 1'b1) saw_commit = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_commit !== 1'b0) $display("FAIL clear_no_commit: got commit pulse want none");
    else n_pass++;
  endtask

  task automatic test_run();
    bit wait_ok = 1'b1;
    bit ok_all = 1'b1;
    bit ok;
    int w;
    logic [GEN_W-1:0] gens [1:16];
    row_ack_i = 1'b1;
    pulse(1, 0, 0);
    for (int g = 1; g <= 16; g++) begin
      w = 0;
      while (state_o === S_WAIT && w < 10) begin
        w++;
        tick();
      end
      if (w != TICK_DIV || state_o !== S_COMPUTE) wait_ok = 1'b0;
      wait_state(S_COMMIT, 25, ok);
      if (!ok) ok_all = 1'b0;
      tick();
      gens[g] = gen_cnt_o;
    end
    n_checks++;
    if (wait_ok !== 1'b1) $display("FAIL run_wait_len: got WAIT length != %0d want %0d", TICK_DIV, TICK_DIV);
    else n_pass++;
    n_checks++;
    if (ok_all !== 1'b1) $display("FAIL run_timeout: got missing COMMIT want 16 commits");
    else n_pass++;
    n_checks++;
    if (gens[15] !== 4'd15) $display("FAIL run_gen15: got %0d want 15", gens[15]);
    else n_pass++;
    n_checks++;
    if (gens[16] !== 4'd0) $display("FAIL run_gen_wrap: got %0d want 0", gens[16]);
    else n_pass++;
    n_checks++;
    if (state_o !== S_WAIT) $display("FAIL run_rearm: got state=%0d want %0d", state_o, S_WAIT);
    else n_pass++;
    pulse(1, 0, 0);
    n_checks++;
    if (state_o !== S_PAUSED) $display("FAIL run_pause_wait: got state=%0d want %0d", state_o, S_PAUSED);
    else n_pass++;
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if ({state_o, gen_cnt_o} !== {S_PAUSED, 4'd0})
      $display("FAIL run_pause_hold: got state=%0d gen=%0d want 1 0", state_o, gen_cnt_o);
    else n_pass++;
  endtask

  task automatic test_run_step_same();
    bit ok;
    row_ack_i = 1'b1;
    pulse(1, 1, 0);
    n_checks++;
    if (state_o !== S_WAIT) $display("FAIL runstep_wait: got state=%0d want %0d", state_o, S_WAIT);
    else n_pass++;
    wait_state(S_COMMIT, 30, ok);
    tick();
    n_checks++;
    if ({ok, state_o, gen_cnt_o} !== {1'b1, S_WAIT, 4'd1})
      $display("FAIL runstep_runmode: got ok=%b state=%0d gen=%0d want 1 2 1", ok, state_o, gen_cnt_o);
    else n_pass++;
    wait_state(S_COMPUTE, 10, ok);
    tick();
    tick();
    tick();
    pulse(1, 0, 0);
    n_checks++;
    if ({ok, state_o} !== {1'b1, S_COMPUTE})
      $display("FAIL runpause_compute: got ok=%b state=%0d want 1 3", ok, state_o);
    else n_pass++;
    wait_state(S_COMMIT, 30, ok);
    n_checks++;
    if ({ok, commit_o} !== 2'b11) $display("FAIL runpause_commit: got ok=%b commit=%b want 1 1", ok, commit_o);
    else n_pass++;
    tick();
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if ({state_o, gen_cnt_o} !== {S_PAUSED, 4'd2})
      $display("FAIL runpause_after: got state=%0d gen=%0d want 1 2", state_o, gen_cnt_o);
    else n_pass++;
  endtask

  task automatic test_stable();
    bit ok;
    row_ack_i = 1'b1;
`ifdef GOL_STABLE_DETECT_EN
    row_changed_i = 1'b0;
    pulse(1, 0, 0);
    wait_state(S_COMMIT, 30, ok);
    n_checks++;
    if ({ok, commit_o} !== 2'b11) $display("FAIL stable_commit: got ok=%b commit=%b want 1 1", ok, commit_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({state_o, gen_cnt_o, stable_o} !== {S_PAUSED, 4'd2, 1'b1})
      $display("FAIL stable_after: got state=%0d gen=%0d stable=%b want 1 2 1", state_o, gen_cnt_o, stable_o);
    else n_pass++;
    row_changed_i = 1'b1;
    pulse(0, 1, 0);
    n_checks++;
    if ({state_o, stable_o} !== {S_COMPUTE, 1'b0})
      $display("FAIL stable_clear_on_compute: got state=%0d stable=%b want 3 0", state_o, stable_o);
    else n_pass++;
    wait_state(S_COMMIT, 30, ok);
    tick();
    n_checks++;
    if ({ok, state_o, gen_cnt_o, stable_o} !== {1'b1, S_PAUSED, 4'd3, 1'b0})
      $display("FAIL stable_changed_gen: got ok=%b state=%0d gen=%0d stable=%b want 1 1 3 0",
               ok, state_o, gen_cnt_o, stable_o);
    else n_pass++;
`else
    row_changed_i = 1'b0;
    pulse(0, 1, 0);
    wait_state(S_COMMIT, 30, ok);
    tick();
    n_checks++;
    if ({ok, state_o, gen_cnt_o, stable_o} !== {1'b1, S_PAUSED, 4'd3, 1'b0})
      $display("FAIL nostable_gen: got ok=%b state=%0d gen=%0d stable=%b want 1 1 3 0",
               ok, state_o, gen_cnt_o, stable_o);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_step();
    test_ack_delay();
    test_clear();
    test_run();
    test_run_step_same();
    test_stable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
